dirsak_neuron: RTL and testbench

Single-neuron forward-pass engine used for the arm joint blocks (dirsak; el is the same RTL with different parameters). On a forward_enable request it reads N_INPUTS activations and N_INPUTS weights plus one bias from the board's external asynchronous 16-bit SRAM. It computes a fixed-point dot product plus bias with optional ReLU, and writes the 16-bit result back to SRAM. It owns the SRAM bus exclusively and releases it, with DQ high-Z, when idle.

---
 rtl/dirsak_neuron.sv | 153 +++++++++++++++
 tb/tb_dirsak_neuron.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dirsak_neuron.sv
// rtl/dirsak_neuron.sv - single-neuron dot product + bias + optional ReLU over an async 16-bit SRAM
// Moore FSM: the SRAM strobes/address are decoded from the state and index only.
module dirsak_neuron #(
  parameter int          N_INPUTS  = 8,
  parameter int          FRAC_BITS = 8,
  parameter logic [17:0] X_BASE    = 18'h00000,
  parameter logic [17:0] W_BASE    = 18'h00100,
  parameter logic [17:0] B_ADDR    = 18'h00200,
  parameter logic [17:0] OUT_ADDR  = 18'h00300,
  parameter bit          RELU      = 1'b1
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic        forward_enable,
  inout  wire  [15:0] sram_DQ_mem,
  output logic [17:0] sram_ADDR_mem,
  output logic        sram_UB_N_mem,
  output logic        sram_LB_N_mem,
  output logic        sram_WE_N_mem,
  output logic        sram_CE_N_mem,
  output logic        sram_OE_N_mem
);

  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_INPUTS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_X, S_RD_W, S_MAC, S_RD_B, S_ACT, S_WR, S_WR_END, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      i_q, i_d;
  logic signed [39:0] acc_q, acc_d;
  logic signed [15:0] x_q, x_d, w_q, w_d, b_q, b_d, y_q, y_d;

  logic signed [31:0] prod;
  logic signed [39:0] acc_sh, b_ext, sum;
  logic        [15:0] sat;
  logic        [15:0] y_act;
  logic               dq_oe;

  assign prod   = x_q * w_q;
  assign acc_sh = acc_q >>> FRAC_BITS;
  assign b_ext  = {{24{b_q[15]}}, b_q};
  assign sum    = acc_sh + b_ext;
  assign sat    = (sum > 40'sd32767)  ? 16'h7FFF :
                  (sum < -40'sd32768) ? 16'h8000 : sum[15:0];
  assign y_act  = (RELU && sat[15]) ? 16'h0000 : sat;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      w_q     <= w_d;
      b_q     <= b_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w_d     = w_q;
    b_d     = b_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (forward_enable) begin
          state_d = S_RD_X;
          i_d     = '0;
          acc_d   = '0;
        end
      end
      S_RD_X: begin
        x_d     = sram_DQ_mem;
        state_d = S_RD_W;
      end
      S_RD_W: begin
        w_d     = sram_DQ_mem;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + {{8{prod[31]}}, prod};
        if (i_q == I_LAST) begin
          state_d = S_RD_B;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_RD_X;
        end
      end
      S_RD_B: begin
        b_d     = sram_DQ_mem;
        state_d = S_ACT;
      end
      S_ACT: begin
        y_d     = y_act;
        state_d = S_WR;
      end
      S_WR:     state_d = S_WR_END;
      S_WR_END: state_d = S_DONE;
      S_DONE: begin
        // one pass per request: wait for the level request to drop
        if (!forward_enable) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sram_ADDR_mem = '0;
    sram_CE_N_mem = 1'b1;
    sram_OE_N_mem = 1'b1;
    sram_WE_N_mem = 1'b1;
    sram_UB_N_mem = 1'b1;
    sram_LB_N_mem = 1'b1;
    dq_oe         = 1'b0;
    case (state_q)
      S_RD_X, S_RD_W, S_RD_B: begin
        sram_CE_N_mem = 1'b0;
        sram_OE_N_mem = 1'b0;
        sram_UB_N_mem = 1'b0;
        sram_LB_N_mem = 1'b0;
        if (state_q == S_RD_X)      sram_ADDR_mem = X_BASE + 18'(i_q);
        else if (state_q == S_RD_W) sram_ADDR_mem = W_BASE + 18'(i_q);
        else                        sram_ADDR_mem = B_ADDR;
      end
      S_WR, S_WR_END: begin
        sram_ADDR_mem = OUT_ADDR;
        sram_CE_N_mem = 1'b0;
        sram_UB_N_mem = 1'b0;
        sram_LB_N_mem = 1'b0;
        sram_WE_N_mem = (state_q == S_WR) ? 1'b0 : 1'b1;
        dq_oe         = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_DQ_mem = dq_oe ? y_q : 16'hzzzz;

endmodule

// File: tb/tb_dirsak_neuron.sv
// tb/tb_dirsak_neuron.sv - scoreboard bench for dirsak_neuron, RELU=0 and RELU=1 instances in lockstep
module tb_dirsak_neuron;

  localparam int          N        = 4;
  localparam logic [17:0] X_BASE   = 18'h00000;
  localparam logic [17:0] W_BASE   = 18'h00100;
  localparam logic [17:0] B_ADDR   = 18'h00200;
  localparam logic [17:0] OUT_ADDR = 18'h00300;

  logic CLOCK = 1'b0;
  logic reset = 1'b1;
  logic fe    = 1'b0;

  wire  [15:0] dq0, dq1;
  logic [17:0] addr0, addr1;
  logic ub0, lb0, we0, ce0, oe0;
  logic ub1, lb1, we1, ce1, oe1;

  logic [15:0] mx [N];
  logic [15:0] mw [N];
  logic [15:0] mb;

  logic [17:0] exp_addr [$];
  logic [15:0] exp_y0 [$];
  logic [15:0] exp_y1 [$];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int cyc0 = 0;
  bit lat_arm = 1'b0;

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc++;

  dirsak_neuron #(.N_INPUTS(N), .FRAC_BITS(8), .X_BASE(X_BASE), .W_BASE(W_BASE),
                  .B_ADDR(B_ADDR), .OUT_ADDR(OUT_ADDR), .RELU(1'b0)) u0 (
    .CLOCK(CLOCK), .reset(reset), .forward_enable(fe), .sram_DQ_mem(dq0),
    .sram_ADDR_mem(addr0), .sram_UB_N_mem(ub0), .sram_LB_N_mem(lb0),
    .sram_WE_N_mem(we0), .sram_CE_N_mem(ce0), .sram_OE_N_mem(oe0));

  dirsak_neuron #(.N_INPUTS(N), .FRAC_BITS(8), .X_BASE(X_BASE), .W_BASE(W_BASE),
                  .B_ADDR(B_ADDR), .OUT_ADDR(OUT_ADDR), .RELU(1'b1)) u1 (
    .CLOCK(CLOCK), .reset(reset), .forward_enable(fe), .sram_DQ_mem(dq1),
    .sram_ADDR_mem(addr1), .sram_UB_N_mem(ub1), .sram_LB_N_mem(lb1),
    .sram_WE_N_mem(we1), .sram_CE_N_mem(ce1), .sram_OE_N_mem(oe1));

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    int ia;
    ia = int'(a);
    if (ia >= int'(X_BASE) && ia < int'(X_BASE) + N) return mx[ia - int'(X_BASE)];
    if (ia >= int'(W_BASE) && ia < int'(W_BASE) + N) return mw[ia - int'(W_BASE)];
    if (a == B_ADDR) return mb;
    return 16'hDEAD;
  endfunction

  assign dq0 = (!ce0 && !oe0 && we0) ? sram_rd(addr0) : 16'hzzzz;
  assign dq1 = (!ce1 && !oe1 && we1) ? sram_rd(addr1) : 16'hzzzz;

  // Q8.8 reference: exact integer dot product, floor division by 256, clamp
  function automatic logic [15:0] model(input bit relu);
    longint acc, q, s;
    logic [15:0] r;
    acc = 0;
    for (int i = 0; i < N; i++)
      acc += longint'($signed(mx[i])) * longint'($signed(mw[i]));
    q = acc / 256;
    if (acc < 0 && (acc % 256) != 0) q = q - 1;
    s = q + longint'($signed(mb));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    r = s[15:0];
    return r;
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic bit bus_idle();
    return ce0 && oe0 && we0 && ub0 && lb0 && (addr0 == 18'h0) &&
           ce1 && oe1 && we1 && ub1 && lb1 && (addr1 == 18'h0);
  endfunction

  // monitor: pops the scoreboard whenever either DUT drives a read or a write strobe
  always @(negedge CLOCK) begin
    logic [17:0] ea;
    logic [15:0] ey;
    if (cyc > 0) begin
      if ((!ce0 && !oe0) || (!ce1 && !oe1)) begin
        chk(exp_addr.size() != 0, "read_expected", exp_addr.size(), 1);
        if (exp_addr.size() != 0) begin
          ea = exp_addr.pop_front();
          if (lat_arm) begin
            cyc0 = cyc;
            lat_arm = 1'b0;
          end
          chk(!ce0 && !oe0 && we0 && !ub0 && !lb0 && addr0 == ea, "read_addr0", addr0, ea);
          chk(!ce1 && !oe1 && we1 && !ub1 && !lb1 && addr1 == ea, "read_addr1", addr1, ea);
        end
      end
      if (!ce0 && !we0) begin
        chk(exp_y0.size() != 0, "write_expected0", exp_y0.size(), 1);
        if (exp_y0.size() != 0) begin
          ey = exp_y0.pop_front();
          chk(addr0 == OUT_ADDR && oe0 && !ub0 && !lb0, "write_addr0", addr0, OUT_ADDR);
          chk(dq0 == ey, "write_data0", dq0, ey);
          chk(cyc - cyc0 == 3 * N + 2, "latency", cyc - cyc0, 3 * N + 2);
        end
      end
      if (!ce1 && !we1) begin
        chk(exp_y1.size() != 0, "write_expected1", exp_y1.size(), 1);
        if (exp_y1.size() != 0) begin
          ey = exp_y1.pop_front();
          chk(addr1 == OUT_ADDR && oe1, "write_addr1", addr1, OUT_ADDR);
          chk(dq1 == ey, "write_data1", dq1, ey);
        end
      end
    end
  end

  task automatic push_pass();
    for (int i = 0; i < N; i++) begin
      exp_addr.push_back(X_BASE + 18'(i));
      exp_addr.push_back(W_BASE + 18'(i));
    end
    exp_addr.push_back(B_ADDR);
    exp_y0.push_back(model(1'b0));
    exp_y1.push_back(model(1'b1));
    lat_arm = 1'b1;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 200 && (exp_y0.size() != 0 || exp_y1.size() != 0); c++)
      @(posedge CLOCK);
    chk(exp_y0.size() == 0 && exp_y1.size() == 0 && exp_addr.size() == 0, name,
        exp_y0.size() + exp_y1.size() + exp_addr.size(), 0);
    repeat (4) @(posedge CLOCK);
    #1;
  endtask

  task automatic run_pass(input string name);
    push_pass();
    @(posedge CLOCK); #1 fe = 1'b1;
    @(posedge CLOCK); #1 fe = 1'b0;
    wait_done(name);
  endtask

  task automatic set_all(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < N; i++) begin
      mx[i] = xv;
      mw[i] = wv;
    end
    mb = bv;
  endtask

  initial begin
    bit idle_ok;
    set_all(16'h0, 16'h0, 16'h0);
    repeat (6) @(posedge CLOCK);
    #1 reset = 1'b0;

    idle_ok = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLOCK);
      if (!bus_idle()) idle_ok = 1'b0;
    end
    chk(idle_ok, "idle_bus", {31'b0, idle_ok}, 1);
    @(posedge CLOCK); #1;

    set_all(16'h0100, 16'h0, 16'h0010);
    mw[0] = 16'h0100; mw[1] = 16'h0200; mw[2] = 16'hFF00; mw[3] = 16'h0080;
    chk(model(1'b0) == 16'h0290, "model_basic", model(1'b0), 16'h0290);
    run_pass("basic_done");

    set_all(16'h7FFF, 16'h7FFF, 16'h0000);
    run_pass("sat_pos_done");
    set_all(16'h7FFF, 16'h8000, 16'h0000);
    run_pass("sat_neg_done");
    set_all(16'h0100, 16'hFF00, 16'h0000);
    chk(model(1'b0) == 16'hFC00, "model_relu", model(1'b0), 16'hFC00);
    run_pass("relu_done");

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        mx[i] = (r < 6) ? 16'($urandom_range(0, 16'h0800)) - 16'h0400 : 16'($urandom);
        mw[i] = (r < 6) ? 16'($urandom_range(0, 16'h0800)) - 16'h0400 : 16'($urandom);
      end
      mb = 16'($urandom);
      run_pass("random_done");
    end

    // held request: exactly one pass while the level stays high
    set_all(16'h0180, 16'h0040, 16'hFFF0);
    push_pass();
    @(posedge CLOCK); #1 fe = 1'b1;
    repeat (200) @(posedge CLOCK);
    #1 fe = 1'b0;
    chk(exp_y0.size() == 0 && exp_y1.size() == 0, "held_one_pass", exp_y0.size(), 0);
    repeat (3) @(posedge CLOCK);
    #1;
    run_pass("held_second_pass");

    // reset during the 5th pass cycle: only X0,W0,X1,W1 reads, never a write
    set_all(16'h0200, 16'h0300, 16'h0001);
    exp_addr.push_back(X_BASE);
    exp_addr.push_back(W_BASE);
    exp_addr.push_back(X_BASE + 18'd1);
    exp_addr.push_back(W_BASE + 18'd1);
    lat_arm = 1'b1;
    @(posedge CLOCK); #1 fe = 1'b1;
    @(posedge CLOCK); #1 fe = 1'b0;
    repeat (4) @(posedge CLOCK);
    #1 reset = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    chk(bus_idle(), "reset_bus_release", {31'b0, bus_idle()}, 1);
    @(posedge CLOCK); #1 reset = 1'b0;
    repeat (20) @(posedge CLOCK);
    #1;
    chk(exp_addr.size() == 0, "reset_reads", exp_addr.size(), 0);
    run_pass("after_reset_done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
